// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer/slice-index widths and the full/empty flag encoding.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  // Pointer width for a storage of 'depth' entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Slice counter width for 'ratio' narrow slices per word (at least one bit).
  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/width_down_fifo_mem.sv
// Register-based word storage: one synchronous write port, asynchronous read, no reset.
module width_down_fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/width_down_fifo.sv
// Width-reducing FWFT FIFO: stores IN_WIDTH words, emits RATIO narrow slices per word.
// Define WIDTH_DOWN_FIFO_MSB_FIRST_EN to emit the most-significant slice first.
module width_down_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned RATIO     = 2,
  parameter int unsigned DEPTH     = 8,
  localparam int unsigned OUT_WIDTH = IN_WIDTH / RATIO,
  localparam int unsigned LVL_W     = ptr_width(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [LVL_W-1:0]     level
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned IDX_W = idx_width(RATIO);

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [IDX_W-1:0]    slice_q, slice_idx;
  logic [LVL_W-1:0]    level_q;
  fifo_flags_t         flags;
  logic                wr_en, rd_en, word_done;
  logic [IN_WIDTH-1:0] rd_word, rd_shift;

  // Flags come from registered level only, so a same-cycle read never frees space.
  always_comb begin
    flags       = '0;
    flags.full  = (level_q == LVL_W'(DEPTH));
    flags.empty = (level_q == '0);
  end

  assign in_ready  = !flags.full;
  assign out_valid = !flags.empty;
  assign level     = level_q;

  always_comb begin
    wr_en     = in_valid && in_ready && !flush;
    rd_en     = out_valid && out_ready;
    word_done = rd_en && (slice_q == IDX_W'(RATIO - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      slice_q <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      slice_q <= '0;
      level_q <= '0;
    end else begin
      if (wr_en)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (word_done) rd_ptr <= rd_ptr + PTR_W'(1);
      if (rd_en)     slice_q <= word_done ? '0 : slice_q + IDX_W'(1);
      level_q <= level_q + LVL_W'(wr_en) - LVL_W'(word_done);
    end
  end

  width_down_fifo_mem #(
    .WIDTH (IN_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

`ifdef WIDTH_DOWN_FIFO_MSB_FIRST_EN
  assign slice_idx = IDX_W'(RATIO - 1) - slice_q;
`else
  assign slice_idx = slice_q;
`endif

  // Uninitialised storage must never leak out, so the slice is masked when empty.
  always_comb begin
    rd_shift = rd_word >> (32'(slice_idx) * OUT_WIDTH);
    out_data = out_valid ? rd_shift[OUT_WIDTH-1:0] : '0;
  end

endmodule

// File: doc/width_down_fifo.md
WIDTH_DOWN_FIFO -- requirements
Module: width_down_fifo

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: write word width in bits.
REQ-002 SHALL have parameter RATIO, default 2: narrow slices per write word; power of 2, at least 2; OUT_WIDTH = IN_WIDTH/RATIO.
REQ-003 SHALL have parameter DEPTH, default 8: storage in write words; power of 2, at least 2.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1: synchronous clear of contents.
REQ-007 SHALL have port in_valid, input, 1: write request.
REQ-008 SHALL have port in_data, input, IN_WIDTH: write word.
REQ-009 SHALL have port in_ready, output, 1: write accepted when in_valid && in_ready.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid slice.
REQ-011 SHALL have port out_data, output, OUT_WIDTH: current slice.
REQ-012 SHALL have port out_ready, input, 1: slice consumed when out_valid && out_ready.
REQ-013 SHALL have port level, output, clog2(DEPTH)+1: stored write words, including a partly read word.

Function
REQ-014 SHALL provide first-word-fall-through: out_data is valid in the same cycle out_valid is high, with no read latency.
REQ-015 SHALL make a write visible on out_valid one cycle after the accepting edge.
REQ-016 SHALL drive in_ready = (level != DEPTH), computed from registered state only, so a read in the same cycle does not free space for a write.
REQ-017 SHALL drive out_valid = (level != 0).
REQ-018 SHALL emit slices of each word in order 0..RATIO-1; slice k is in_data[k*OUT_WIDTH +: OUT_WIDTH] (LSB first).
REQ-019 SHALL advance the slice counter on each consumed slice.
REQ-020 SHALL, on consuming slice RATIO-1, wrap the slice counter to 0, advance the read pointer, and decrement level.
REQ-021 SHALL, on a simultaneous accepted write and word-completing read, leave level unchanged and move both pointers.
REQ-022 SHALL let read and write pointers wrap modulo DEPTH without a gap.
REQ-023 SHALL ignore out_ready while out_valid is low, and ignore in_valid while in_ready is low; state SHALL not change in either case.
REQ-024 SHALL, when flush is high, zero pointers, slice counter and level at the next edge, discarding any partly read word; a write in the flush cycle SHALL be dropped.
REQ-025 SHALL hold out_data stable while out_valid && !out_ready.

Reset
REQ-026 SHALL, with reset_n low, immediately set level = 0, in_ready = 1, out_valid = 0, pointers and slice counter = 0, and out_data = 0.
REQ-027 SHALL not reset storage contents, and out_data SHALL be masked to 0 while out_valid is low.
REQ-028 SHALL abort any transfer in progress when reset is asserted mid-operation; no slice is delivered after reset release until a new write.

Configuration
REQ-029 SHALL, with macro WIDTH_DOWN_FIFO_MSB_FIRST_EN defined, emit slices in order RATIO-1..0 (most-significant slice first).
REQ-030 SHALL, without WIDTH_DOWN_FIFO_MSB_FIRST_EN, use the LSB-first order of REQ-018; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL place the slice-index and pointer width functions (clog2-based) in shared package fifo_pkg.
REQ-032 SHALL place the flag encoding in fifo_pkg if it is reused by other FIFOs.
REQ-033 SHALL implement storage as sub-module width_down_fifo_mem: DEPTH x IN_WIDTH, one write port, asynchronous read, register-based, no reset.
REQ-034 SHALL keep the control logic (pointers, slice counter, level) in the top module.

Verification
REQ-035 SHALL cover basic order (defaults): write 0xDDCCBBAA then 0x44332211, out_ready = 1 -> out_data 0xBBAA, 0xDDCC, 0x2211, 0x4433 on consecutive cycles; level 2,2,1,1,0.
REQ-036 SHALL cover full: 8 writes with out_ready = 0 -> level = 8 and in_ready = 0; a 9th write is ignored; after 2 slices are read, in_ready = 1 on the following cycle.
REQ-037 SHALL cover simultaneous events: level = 8 with the last slice read in the same cycle as in_valid = 1 -> the write is not accepted; next cycle level = 7, in_ready = 1.
REQ-038 SHALL cover wrap: 20 words streamed with random in_valid/out_ready -> the output sequence matches the reference model across pointer wrap.
REQ-039 SHALL cover flush/reset mid-word: read slice 0 of 0x12345678, then flush (or reset_n = 0) -> out_valid = 0 and level = 0 next cycle (immediately for reset); slice 0x1234 is never emitted.
REQ-040 SHALL cover macro on: with WIDTH_DOWN_FIFO_MSB_FIRST_EN defined, write 0xDDCCBBAA -> out_data 0xDDCC then 0xBBAA.
